// File: rtl/shift_operand_stage.sv
// rtl/shift_operand_stage.sv - operand register stage feeding the 16-bit shifter, 2-entry skid buffer with flush
// Optional SHIFT_STAGE_PERF_EN adds saturating stall_cycles / accepted_ops counters.
module shift_operand_stage #(
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [1:0]       funct,
  input  logic [15:0]      rs_data,
  input  logic [15:0]      rt_data,
  input  logic [3:0]       imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      sh_in,
  output logic [3:0]       sh_cnt,
  output logic [1:0]       sh_op,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
`ifdef SHIFT_STAGE_PERF_EN
  ,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      accepted_ops
`endif
);

  logic             vm_q, vm_d, vs_q, vs_d;
  logic             illegal_q, illegal_d;
  logic [15:0]      m_data_q, m_data_d, s_data_q, s_data_d;
  logic [3:0]       m_cnt_q, m_cnt_d, s_cnt_q, s_cnt_d;
  logic [1:0]       m_op_q, m_op_d, s_op_q, s_op_d;
  logic [TAG_W-1:0] m_tag_q, m_tag_d, s_tag_q, s_tag_d;

  logic       dec_legal;
  logic [1:0] dec_op;
  logic [3:0] dec_cnt;
  logic       accept, accept_legal, pop;

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = 2'b00;
    dec_cnt   = imm;
    case (opcode)
      5'b10100: begin dec_legal = 1'b1; dec_op = 2'b00; end
      5'b10101: begin dec_legal = 1'b1; dec_op = 2'b01; end
      5'b10110: begin dec_legal = 1'b1; dec_op = 2'b10; end
      5'b10111: begin dec_legal = 1'b1; dec_op = 2'b11; end
      5'b11010: begin
        dec_legal = 1'b1;
        dec_op    = funct;
        dec_cnt   = rt_data[3:0];
      end
      default: ;
    endcase
  end

  // in_ready depends only on registered state so out_ready never reaches decode combinationally
  assign in_ready     = !vs_q;
  assign accept       = in_valid & in_ready & !flush;
  assign accept_legal = accept & dec_legal;
  assign pop          = vm_q & out_ready;

  always_comb begin
    vm_d      = vm_q;
    vs_d      = vs_q;
    illegal_d = 1'b0;
    m_data_d  = m_data_q;
    m_cnt_d   = m_cnt_q;
    m_op_d    = m_op_q;
    m_tag_d   = m_tag_q;
    s_data_d  = s_data_q;
    s_cnt_d   = s_cnt_q;
    s_op_d    = s_op_q;
    s_tag_d   = s_tag_q;
    if (flush) begin
      vm_d = 1'b0;
      vs_d = 1'b0;
    end else begin
      illegal_d = accept & !dec_legal;
      if (!vm_q) begin
        if (accept_legal) begin
          vm_d     = 1'b1;
          m_data_d = rs_data;
          m_cnt_d  = dec_cnt;
          m_op_d   = dec_op;
          m_tag_d  = in_tag;
        end
      end else if (vs_q) begin
        if (pop) begin
          vs_d     = 1'b0;
          m_data_d = s_data_q;
          m_cnt_d  = s_cnt_q;
          m_op_d   = s_op_q;
          m_tag_d  = s_tag_q;
        end
      end else if (pop && accept_legal) begin
        m_data_d = rs_data;
        m_cnt_d  = dec_cnt;
        m_op_d   = dec_op;
        m_tag_d  = in_tag;
      end else if (pop) begin
        vm_d = 1'b0;
      end else if (accept_legal) begin
        vs_d     = 1'b1;
        s_data_d = rs_data;
        s_cnt_d  = dec_cnt;
        s_op_d   = dec_op;
        s_tag_d  = in_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vm_q      <= 1'b0;
      vs_q      <= 1'b0;
      illegal_q <= 1'b0;
      m_data_q  <= '0;
      m_cnt_q   <= '0;
      m_op_q    <= '0;
      m_tag_q   <= '0;
      s_data_q  <= '0;
      s_cnt_q   <= '0;
      s_op_q    <= '0;
      s_tag_q   <= '0;
    end else begin
      vm_q      <= vm_d;
      vs_q      <= vs_d;
      illegal_q <= illegal_d;
      m_data_q  <= m_data_d;
      m_cnt_q   <= m_cnt_d;
      m_op_q    <= m_op_d;
      m_tag_q   <= m_tag_d;
      s_data_q  <= s_data_d;
      s_cnt_q   <= s_cnt_d;
      s_op_q    <= s_op_d;
      s_tag_q   <= s_tag_d;
    end
  end

  assign out_valid = vm_q;
  assign sh_in     = m_data_q;
  assign sh_cnt    = m_cnt_q;
  assign sh_op     = m_op_q;
  assign out_tag   = m_tag_q;
  assign illegal   = illegal_q;

`ifdef SHIFT_STAGE_PERF_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] accepted_ops_q, accepted_ops_d;

  // Counters survive flush; only reset clears them
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    accepted_ops_d = accepted_ops_q;
    if (vm_q && !out_ready && stall_cycles_q != 16'hFFFF)
      stall_cycles_d = stall_cycles_q + 16'd1;
    if (accept_legal && accepted_ops_q != 16'hFFFF)
      accepted_ops_d = accepted_ops_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      accepted_ops_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      accepted_ops_q <= accepted_ops_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign accepted_ops = accepted_ops_q;
`endif

endmodule

// File: tb/tb_shift_operand_stage.sv
// tb/tb_shift_operand_stage.sv - directed and randomized checks of shift_operand_stage against a queue model
module tb_shift_operand_stage;
  localparam int TAG_W = 3;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [4:0]       opcode;
  logic [1:0]       funct, sh_op;
  logic [15:0]      rs_data, rt_data, sh_in;
  logic [3:0]       imm, sh_cnt;
  logic [TAG_W-1:0] in_tag, out_tag;

  int n_pass = 0;
  int n_total = 0;

  shift_operand_stage #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .sh_in(sh_in),
    .sh_cnt(sh_cnt), .sh_op(sh_op), .out_tag(out_tag), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]      d;
    logic [3:0]       c;
    logic [1:0]       o;
    logic [TAG_W-1:0] t;
  } ent_t;

  ent_t mq[$];
  bit   exp_ill = 0;
  bit   m_acc, m_pop, m_legal;
  ent_t m_e;

  // Reference model: a FIFO of capacity 2 that accepts only when it held fewer than 2 entries
  always @(posedge clk) begin
    if (rst || flush) begin
      mq.delete();
      exp_ill = 0;
    end else begin
      m_legal = 1;
      m_e.d = rs_data;
      m_e.t = in_tag;
      m_e.c = imm;
      case (opcode)
        5'b10100: m_e.o = 2'd0;
        5'b10101: m_e.o = 2'd1;
        5'b10110: m_e.o = 2'd2;
        5'b10111: m_e.o = 2'd3;
        5'b11010: begin m_e.o = funct; m_e.c = rt_data % 16; end
        default: begin m_legal = 0; m_e.o = 2'd0; end
      endcase
      m_acc = in_valid && (mq.size() < 2);
      m_pop = (mq.size() > 0) && out_ready;
      if (m_pop) void'(mq.pop_front());
      if (m_acc && m_legal) mq.push_back(m_e);
      exp_ill = m_acc && !m_legal;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] opc, input logic [1:0] fn,
                       input logic [15:0] rs, input logic [15:0] rt, input logic [3:0] im,
                       input logic [TAG_W-1:0] tg);
    in_valid = v; opcode = opc; funct = fn; rs_data = rs; rt_data = rt; imm = im; in_tag = tg;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; out_ready = 1;
    drive(0, 5'd0, 2'd0, 16'd0, 16'd0, 4'd0, 3'd0);
    tick(); tick();
    rst = 0;
    n_total++;
    if ({out_valid, in_ready, illegal, sh_in, sh_cnt, sh_op, out_tag} !== {1'b0, 1'b1, 1'b0, 16'd0, 4'd0, 2'd0, 3'd0})
      $display("FAIL reset_state: got v=%b r=%b ill=%b in=%h cnt=%h op=%b tag=%h", out_valid, in_ready, illegal, sh_in, sh_cnt, sh_op, out_tag);
    else n_pass++;
  endtask

  task automatic test_roli();
    out_ready = 1;
    drive(1, 5'b10100, 2'd0, 16'h8001, 16'hFFFF, 4'h1, 3'd2);
    tick();
    drive(0, 5'b10100, 2'd0, 16'h0, 16'h0, 4'h0, 3'd0);
    n_total++;
    if ({out_valid, sh_in, sh_cnt, sh_op, out_tag} !== {1'b1, 16'h8001, 4'h1, 2'b00, 3'd2})
      $display("FAIL roli_out: got v=%b in=%h cnt=%h op=%b tag=%h want 1 8001 1 00 2", out_valid, sh_in, sh_cnt, sh_op, out_tag);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL roli_drain: out_valid=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_register_form();
    drive(1, 5'b11010, 2'b11, 16'hF000, 16'h00F3, 4'h9, 3'd5);
    tick();
    drive(0, 5'b0, 2'd0, 16'h0, 16'h0, 4'h0, 3'd0);
    n_total++;
    if ({out_valid, sh_in, sh_cnt, sh_op, out_tag} !== {1'b1, 16'hF000, 4'h3, 2'b11, 3'd5})
      $display("FAIL reg_form: got v=%b in=%h cnt=%h op=%b tag=%h want 1 f000 3 11 5", out_valid, sh_in, sh_cnt, sh_op, out_tag);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_pressure();
    out_ready = 0;
    drive(1, 5'b10101, 2'd0, 16'h00AA, 16'h0, 4'h2, 3'd1);
    tick();
    n_total++;
    if ({in_ready, out_valid, sh_cnt, sh_op} !== {1'b1, 1'b1, 4'h2, 2'b01})
      $display("FAIL bp_first: got r=%b v=%b cnt=%h op=%b want 1 1 2 01", in_ready, out_valid, sh_cnt, sh_op);
    else n_pass++;
    drive(1, 5'b10110, 2'd0, 16'h0055, 16'h0, 4'h5, 3'd2);
    tick();
    drive(0, 5'b0, 2'd0, 16'h0, 16'h0, 4'h0, 3'd0);
    n_total++;
    if ({in_ready, out_valid, sh_in, sh_cnt, sh_op, out_tag} !== {1'b0, 1'b1, 16'h00AA, 4'h2, 2'b01, 3'd1})
      $display("FAIL bp_full_hold: got r=%b v=%b in=%h cnt=%h op=%b tag=%h", in_ready, out_valid, sh_in, sh_cnt, sh_op, out_tag);
    else n_pass++;
    tick();
    n_total++;
    if ({in_ready, sh_in, sh_op} !== {1'b0, 16'h00AA, 2'b01})
      $display("FAIL bp_stable: got r=%b in=%h op=%b want 0 00aa 01", in_ready, sh_in, sh_op);
    else n_pass++;
    out_ready = 1;
    tick();
    n_total++;
    if ({out_valid, sh_in, sh_cnt, sh_op, out_tag, in_ready} !== {1'b1, 16'h0055, 4'h5, 2'b10, 3'd2, 1'b1})
      $display("FAIL bp_second: got v=%b in=%h cnt=%h op=%b tag=%h r=%b", out_valid, sh_in, sh_cnt, sh_op, out_tag, in_ready);
    else n_pass++;
    tick();
    n_total++;
    if ({out_valid, in_ready} !== 2'b01) $display("FAIL bp_empty: got v=%b r=%b want 0 1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_illegal();
    drive(1, 5'b00000, 2'd0, 16'h1234, 16'h0, 4'h3, 3'd4);
    tick();
    drive(0, 5'b0, 2'd0, 16'h0, 16'h0, 4'h0, 3'd0);
    n_total++;
    if ({illegal, out_valid} !== 2'b10) $display("FAIL illegal_pulse: got ill=%b v=%b want 1 0", illegal, out_valid);
    else n_pass++;
    tick();
    n_total++;
    if ({illegal, out_valid} !== 2'b00) $display("FAIL illegal_once: got ill=%b v=%b want 0 0", illegal, out_valid);
    else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 0;
    drive(1, 5'b10101, 2'd0, 16'h1111, 16'h0, 4'h1, 3'd1);
    tick();
    drive(1, 5'b10101, 2'd0, 16'h2222, 16'h0, 4'h2, 3'd2);
    tick();
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL flush_prefill: in_ready=%b want 0", in_ready);
    else n_pass++;
    flush = 1;
    drive(1, 5'b10100, 2'd0, 16'h3333, 16'h0, 4'h3, 3'd3);
    tick();
    flush = 0;
    drive(0, 5'b0, 2'd0, 16'h0, 16'h0, 4'h0, 3'd0);
    out_ready = 1;
    n_total++;
    if ({out_valid, in_ready, illegal} !== 3'b010) $display("FAIL flush_clear: got v=%b r=%b ill=%b want 0 1 0", out_valid, in_ready, illegal);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL flush_no_ghost: out_valid=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    drive(1, 5'b10110, 2'd0, 16'hAAAA, 16'h0, 4'h7, 3'd6);
    tick(); tick();
    drive(0, 5'b0, 2'd0, 16'h0, 16'h0, 4'h0, 3'd0);
    rst = 1; flush = 1;
    tick();
    rst = 0; flush = 0;
    n_total++;
    if ({out_valid, in_ready, illegal, sh_in, sh_cnt, sh_op, out_tag} !== {1'b0, 1'b1, 1'b0, 16'd0, 4'd0, 2'd0, 3'd0})
      $display("FAIL reset_mid: got v=%b r=%b ill=%b in=%h cnt=%h op=%b tag=%h", out_valid, in_ready, illegal, sh_in, sh_cnt, sh_op, out_tag);
    else n_pass++;
    out_ready = 1;
    drive(1, 5'b10111, 2'd0, 16'h1234, 16'h0, 4'hF, 3'd7);
    tick();
    drive(0, 5'b0, 2'd0, 16'h0, 16'h0, 4'h0, 3'd0);
    n_total++;
    if ({out_valid, sh_in, sh_cnt, sh_op, out_tag} !== {1'b1, 16'h1234, 4'hF, 2'b11, 3'd7})
      $display("FAIL srli_after_reset: got v=%b in=%h cnt=%h op=%b tag=%h", out_valid, sh_in, sh_cnt, sh_op, out_tag);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [4:0] opc;
    int errs = 0;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 6))
        0: opc = 5'b10100;
        1: opc = 5'b10101;
        2: opc = 5'b10110;
        3: opc = 5'b10111;
        4, 5: opc = 5'b11010;
        default: opc = 5'($urandom);
      endcase
      drive(1'($urandom_range(0, 3) != 0), opc, 2'($urandom), 16'($urandom), 16'($urandom),
            4'($urandom), 3'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 79) == 0);
      tick();
      n_total++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) || illegal !== exp_ill ||
          (mq.size() > 0 && {sh_in, sh_cnt, sh_op, out_tag} !== mq[0])) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random_cycle%0d: got v=%b r=%b ill=%b in=%h cnt=%h op=%b tag=%h; want v=%b r=%b ill=%b head=%h",
                   i, out_valid, in_ready, illegal, sh_in, sh_cnt, sh_op, out_tag,
                   mq.size() > 0, mq.size() < 2, exp_ill, (mq.size() > 0) ? mq[0] : '0);
      end else n_pass++;
    end
    rst = 0; flush = 0;
    drive(0, 5'b0, 2'd0, 16'h0, 16'h0, 4'h0, 3'd0);
  endtask

  initial begin
    rst = 1; flush = 0; out_ready = 1;
    drive(0, 5'd0, 2'd0, 16'd0, 16'd0, 4'd0, 3'd0);
    test_reset();
    test_roli();
    test_register_form();
    test_back_pressure();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/shift_operand_stage.md
Name: shift_operand_stage

Overview:
- Pipeline stage directly upstream of the 16-bit shifter (In/Cnt/Op interface; Op 00=rotate left, 01=shift left, 10=rotate right, 11=shift right logical).
- Accepts decoded shift instructions from the decode stage and selects the count source (immediate or register).
- Registers the shifter operands behind a valid/ready handshake, with a 2-entry skid buffer and flush, so the shifter sees stable, registered inputs.

Parameters:
TAG_W, 3, width of destination-register tag carried alongside the operands

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  discard all buffered entries (branch/exception)
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage can accept this cycle
opcode  input  5  instruction opcode
funct  input  2  function field, register-form shifts
rs_data  input  16  value to be shifted
rt_data  input  16  register shift count source; low 4 bits used
imm  input  4  immediate shift count
in_tag  input  TAG_W  destination register tag
out_valid  output  1  sh_* hold a valid operation
out_ready  input  1  downstream consumes this cycle
sh_in  output  16  to shifter In
sh_cnt  output  4  to shifter Cnt
sh_op  output  2  to shifter Op
out_tag  output  TAG_W  tag accompanying result
illegal  output  1  one-cycle pulse: non-shift opcode accepted and dropped

Behaviour:
- Decode (on accept):
  - 10100 ROLI → op 00, cnt=imm
  - 10101 SLLI → op 01, cnt=imm
  - 10110 RORI → op 10, cnt=imm
  - 10111 SRLI → op 11, cnt=imm
  - 11010 → op=funct, cnt=rt_data[3:0]
  - Any other opcode: accepted (consumes handshake), not stored; illegal=1 on the following cycle.
- Storage: main entry M (drives outputs) and skid entry S; valid bits vM, vS.
- in_ready = !vS (registered state only; no combinational path from out_ready).
- accept = in_valid & in_ready & !flush; pop = out_valid & out_ready.
- Transitions:
  - Empty, accept → M loaded; out_valid next cycle (latency 1).
  - M full, pop & accept → M ← new entry.
  - M full, !pop & accept → S ← new entry; in_ready=0 next cycle.
  - M full, pop & !accept: S full → M ← S, vS=0; S empty → vM=0.
  - M and S full, pop → M ← S, vS=0; no accept possible that cycle.
- Ordering strictly FIFO; at most 2 entries buffered; no drop except illegal opcode or flush.
- Output stability: while out_valid & !out_ready, sh_in/sh_cnt/sh_op/out_tag are held unchanged.
- flush: next cycle vM=vS=0, out_valid=0, in_ready=1. Input presented in the flush cycle is not accepted. flush has priority over accept and pop; illegal is not raised for a flushed input.
- Count 0 passes through unmodified (sh_cnt=0); the shifter handles it.
- Reset (also mid-operation): vM=vS=0, out_valid=0, in_ready=1, illegal=0, sh_in=0, sh_cnt=0, sh_op=00, out_tag=0. Reset has priority over flush.

Optional Feature:
SHIFT_STAGE_PERF_EN
- Defined: adds output stall_cycles (16 bits) and output accepted_ops (16 bits).
  - stall_cycles increments each cycle out_valid & !out_ready.
  - accepted_ops increments on each accept of a legal shift.
  - Both saturate at 16'hFFFF; cleared by rst only (not by flush).
- Not defined: neither port nor counter exists; behaviour otherwise identical.

Test Plan:
- ROLI, rs_data=16'h8001, imm=4'h1, out_ready=1 → one cycle later out_valid=1, sh_in=16'h8001, sh_cnt=1, sh_op=00; out_valid=0 on the next cycle.
- Register form: opcode 11010, funct=2'b11, rt_data=16'h00F3, rs_data=16'hF000 → sh_op=11, sh_cnt=3 (upper rt bits ignored).
- Back-pressure: out_ready=0, issue SLLI imm=2 then RORI imm=5 → in_ready=0 after the second accept, outputs hold SLLI; raise out_ready → SLLI then RORI in consecutive cycles, in_ready returns to 1.
- Illegal: opcode 00000 with in_valid=1 → accepted, illegal=1 for exactly one cycle, out_valid stays 0.
- Flush with 2 entries buffered and in_valid=1 → next cycle out_valid=0, in_ready=1, flushed-cycle input never appears at the output.
- Reset asserted with both entries full → next cycle all outputs at reset values; a subsequent SRLI imm=4'hF emerges with sh_cnt=15, sh_op=11.
